// File: rtl/cross_bar_slave_arb.sv
// Per-slave arbiter of the cross bar: decodes the slave select, grants one master,
// forwards its request and routes in-order read responses through a tag FIFO.
// Build option: define CROSS_BAR_FIXED_PRIO_EN for fixed priority (lowest index wins).
module cross_bar_slave_arb #(
    parameter int unsigned MASTER_N = 4,
    parameter int unsigned SLAVE_W  = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SLAVE_ID = 0,
    parameter int unsigned RD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MASTER_N-1:0]          m_req,
    input  logic [MASTER_N*ADDR_W-1:0]   m_addr,
    input  logic [MASTER_N-1:0]          m_cmd,
    input  logic [MASTER_N*DATA_W-1:0]   m_wdata,
    output logic [MASTER_N-1:0]          m_ack,
    output logic [MASTER_N-1:0]          m_resp,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_cmd,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_ack,
    input  logic                         s_resp,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic                         err
);

    localparam int unsigned IDX_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
    localparam int unsigned PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RD_DEPTH + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [IDX_W-1:0]    gnt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    cand;
    logic                found;
    logic [MASTER_N-1:0] eligible;

    logic [ADDR_W-1:0]   addr_arr  [MASTER_N];
    logic [DATA_W-1:0]   wdata_arr [MASTER_N];

    logic [IDX_W-1:0]    fifo_mem [RD_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    // Per-master views of the flattened buses plus address decode
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < MASTER_N; i++) begin
            addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
            eligible[i]  = m_req[i] &&
                           (m_addr[i*ADDR_W + ADDR_W - 1 -: SLAVE_W] == SLAVE_W'(SLAVE_ID));
        end
    end

    // First eligible master searching upward from ptr with wrap
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < MASTER_N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % MASTER_N);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign fifo_full  = (count == CNT_W'(RD_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = (state == GRANT) && s_ack && !m_cmd[gnt];
    assign pop        = s_resp && !fifo_empty;

    // Slave-side forwarding and master-side strobes
    always_comb begin
        m_ack  = '0;
        m_resp = '0;
        if (state == GRANT) begin
            m_ack[gnt] = s_ack;
        end
        if (pop) begin
            m_resp[fifo_mem[rd_ptr]] = 1'b1;
        end
    end

    assign s_req   = (state == GRANT);
    assign s_addr  = addr_arr[gnt];
    assign s_cmd   = m_cmd[gnt];
    assign s_wdata = wdata_arr[gnt];
    assign m_rdata = s_rdata;

    // Arbitration FSM, round-robin pointer, FIFO pointers and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found && !fifo_full) begin
                        gnt   <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (s_ack) begin
                        state <= IDLE;
`ifdef CROSS_BAR_FIXED_PRIO_EN
                        ptr   <= '0;
`else
                        ptr   <= (gnt == IDX_W'(MASTER_N - 1)) ? '0 : gnt + IDX_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            if (s_resp && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Scoreboard bench for cross_bar_slave_arb: random masters and slave, a transaction-level
// reference model predicting grants and response routing.
module tb_cross_bar_slave_arb;

    localparam int unsigned N     = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SID   = 1;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_cmd, m_ack, m_resp;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            s_req, s_cmd, s_ack, s_resp, err;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;

    logic [AW-1:0]   addr_v  [N];
    logic [DW-1:0]   wdata_v [N];
    int              wrong_timer [N];

    typedef struct {
        int            m;
        logic [AW-1:0] addr;
        logic          cmd;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        logic [N-1:0]  resp;
        logic [DW-1:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   rdq[$];

    int   vectors    = 0;
    int   miscompares = 0;
    bit   busy;
    int   win;
    int   rr;
    bit   err_exp;
    logic [N-1:0] acked;

    int   req_pct, ack_pct, resp_pct, wrong_pct;
    bit   rd_only, wr_only;

    always #5 clk = ~clk;

    cross_bar_slave_arb #(
        .MASTER_N (N),
        .SLAVE_W  (2),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SLAVE_ID (SID),
        .RD_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_cmd   (m_cmd),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_resp  (m_resp),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_cmd   (s_cmd),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_resp  (s_resp),
        .s_rdata (s_rdata),
        .err     (err)
    );

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = addr_v[i];
            m_wdata[i*DW +: DW] = wdata_v[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit elig(input int i);
        return m_req[i] && (addr_v[i][AW-1 -: 2] == 2'(SID));
    endfunction

    // Reference model: slave port is either free or owned by one granted master
    always @(negedge clk) begin
        int   pre;
        int   c;
        bit   found;
        gnt_t g;
        if (rst) begin
            busy    = 1'b0;
            rr      = 0;
            err_exp = 1'b0;
            rdq.delete();
            gq.delete();
        end else begin
            check("s_req", 64'(s_req), 64'(busy));
            if (!(busy && s_ack)) check("m_ack_idle", 64'(m_ack), 64'(0));
            check("err", 64'(err), 64'(err_exp));
            pre = rdq.size();
            if (s_resp) begin
                if (pre == 0) err_exp = 1'b1;
                else void'(rdq.pop_front());
            end
            if (busy) begin
                if (s_ack) begin
                    if (!m_cmd[win]) rdq.push_back(win);
`ifndef CROSS_BAR_FIXED_PRIO_EN
                    rr = (win + 1) % N;
`endif
                    busy = 1'b0;
                end
            end else if (pre != DEPTH) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (rr + k) % N;
                    if (!found && elig(c)) begin
                        found   = 1'b1;
                        g.m     = c;
                        g.addr  = addr_v[c];
                        g.cmd   = m_cmd[c];
                        g.wdata = wdata_v[c];
                    end
                end
                if (found) begin
                    gq.push_back(g);
                    busy = 1'b1;
                    win  = g.m;
                end
            end
        end
    end

    // Monitor: compares every handshake and every response against the queues
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        acked = rst ? '0 : m_ack;
        if (!rst) begin
            if (s_req && s_ack) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 64'(s_req && s_ack), 64'(0));
                end else begin
                    g = gq.pop_front();
                    check("m_ack", 64'(m_ack), 64'(N'(1) << g.m));
                    check("s_addr", 64'(s_addr), 64'(g.addr));
                    check("s_cmd", 64'(s_cmd), 64'(g.cmd));
                    check("s_wdata", 64'(s_wdata), 64'(g.wdata));
                end
            end
            if (s_resp) begin
                if (rq.size() == 0) begin
                    check("resp_unexpected", 64'(s_resp), 64'(0));
                end else begin
                    r = rq.pop_front();
                    check("m_resp", 64'(m_resp), 64'(r.resp));
                    check("m_rdata", 64'(m_rdata), 64'(r.data));
                end
            end else begin
                check("m_resp_idle", 64'(m_resp), 64'(0));
            end
        end
    end

    task automatic drive_resp(input logic [DW-1:0] data);
        rsp_t r;
        r.resp = '0;
        if (rdq.size() > 0) r.resp[rdq[0]] = 1'b1;
        r.data  = data;
        s_resp  = 1'b1;
        s_rdata = data;
        rq.push_back(r);
    endtask

    task automatic issue(input int i);
        int o;
        m_req[i]   = 1'b1;
        m_cmd[i]   = rd_only ? 1'b0 : (wr_only ? 1'b1 : 1'($urandom_range(1)));
        wdata_v[i] = $urandom();
        if ($urandom_range(99) < wrong_pct) begin
            o = $urandom_range(2);
            if (o >= SID) o++;
            addr_v[i]      = {2'(o), 30'($urandom())};
            wrong_timer[i] = $urandom_range(8, 1);
        end else begin
            addr_v[i]      = {2'(SID), 30'($urandom())};
            wrong_timer[i] = 0;
        end
    endtask

    // One clock of master and slave behaviour, driven just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_req[i]) begin
                if (acked[i]) begin
                    m_req[i] = 1'b0;
                end else if (wrong_timer[i] > 0) begin
                    wrong_timer[i]--;
                    if (wrong_timer[i] == 0) m_req[i] = 1'b0;
                end
            end else if ($urandom_range(99) < req_pct) begin
                issue(i);
            end
        end
        s_ack   = !rst && ($urandom_range(99) < ack_pct);
        s_resp  = 1'b0;
        s_rdata = $urandom();
        if (!rst && rdq.size() > 0 && $urandom_range(99) < resp_pct) drive_resp($urandom());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        req_pct  = 0;
        ack_pct  = 100;
        resp_pct = 60;
        while ((m_req != '0 || rdq.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = '0; wdata_v[i] = '0; wrong_timer[i] = 0;
        end
        req_pct = 0; ack_pct = 0; resp_pct = 0; wrong_pct = 0;
        rd_only = 1'b0; wr_only = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("rst_s_req", 64'(s_req), 64'(0));
        check("rst_m_ack", 64'(m_ack), 64'(0));
        check("rst_m_resp", 64'(m_resp), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // Directed read from master 2, response three cycles after the accept
        ack_pct = 100;
        m_req[2] = 1'b1; m_cmd[2] = 1'b0; addr_v[2] = 32'h4000_0010; wdata_v[2] = '0;
        n = 0;
        while (rdq.size() == 0 && n < 10) begin step(); n++; end
        check("rd2_ack_timeout", 64'(n >= 10), 64'(0));
        step(); step(); step();
        drive_resp(32'hDEAD_BEEF);
        @(negedge clk);
        check("rd2_m_resp", 64'(m_resp), 64'(4'b0100));
        check("rd2_m_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));

        // All masters writing continuously with an always-ready slave
        wr_only = 1'b1; req_pct = 100;
        repeat (24) step();
        drain(50);
        wr_only = 1'b0;

        // Reads with no responses fill the tag FIFO, then responses release it
        rd_only = 1'b1; req_pct = 100; ack_pct = 100; resp_pct = 0;
        repeat (16) step();
        req_pct = 0; resp_pct = 30;
        repeat (30) step();
        drain(100);
        rd_only = 1'b0;

        // Master 1 targets another slave and must never be granted
        m_req[1] = 1'b1; m_cmd[1] = 1'b1; addr_v[1] = 32'h8000_0000; wrong_timer[1] = 0;
        repeat (20) step();
        m_req[1] = 1'b0;
        step();

        // Randomized traffic in several mixes
        for (int p = 0; p < 4; p++) begin
            req_pct   = 20 + 25 * p;
            ack_pct   = 90 - 20 * p;
            resp_pct  = 15 + 20 * p;
            wrong_pct = 10;
            repeat (800) step();
        end
        wrong_pct = 0;
        drain(1000);

        // Reset while a grant is held
        ack_pct = 0;
        m_req[3] = 1'b1; m_cmd[3] = 1'b1; addr_v[3] = 32'h4000_1234; wdata_v[3] = 32'h1234_5678;
        n = 0;
        while (!s_req && n < 10) begin step(); n++; end
        check("grant_before_reset", 64'(s_req), 64'(1));
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("midrst_s_req", 64'(s_req), 64'(0));
        check("midrst_m_ack", 64'(m_ack), 64'(0));
        check("midrst_err", 64'(err), 64'(0));
        rst = 1'b0;
        ack_pct = 100;
        repeat (6) step();
        drain(100);

        // Response with nothing outstanding sets a sticky error
        step();
        drive_resp(32'h0BAD_0BAD);
        repeat (6) step();
        @(negedge clk);
        check("err_sticky", 64'(err), 64'(1));

        repeat (4) step();
        check("grants_left", 64'(gq.size()), 64'(0));
        check("resps_left", 64'(rq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
